// File: rtl/dff_trace_checker.sv
// ---------------------------------------------------------------------------
// dff_trace_checker
//
// Response-side checker for the enabled-flop exercise. Every clock of a run
// it samples the stimulus (en, d) and the flop response (q), predicts q from
// the previous cycle's samples and counts cycles and mismatches. Each
// mismatch is recorded as {cycle, en_prev, d_prev, q} in a small show-ahead
// FIFO that a downstream reader drains at its own pace. A run can then be
// judged from the pass/done flags instead of from a text log.
//
// Parameters
//   CYC_W        width of cycle counter, error counter and record cycle field
//   CHECK_CYCLES number of sampled cycles per run (1 .. 2^CYC_W-1)
//   DEPTH        mismatch FIFO depth, power of two, >= 2
//
// Ports
//   i_clk        clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_start      pulse, begins a run from IDLE or DONE (ignored in RUN)
//   i_en         observed flop enable
//   i_d          observed flop data input
//   i_q          observed flop output
//   o_busy       high while a run is in progress
//   o_done       high once the run has finished
//   o_pass       high in DONE when no mismatch was seen and none was dropped
//   o_cycle_cnt  index of the next cycle to be sampled
//   o_err_cnt    mismatch count, saturating
//   o_overflow   sticky, a mismatch record was dropped on a full FIFO
//   o_rec_valid  FIFO holds at least one record
//   i_rec_ready  reader accepts the head record
//   o_rec_data   head record {cycle, en_prev, d_prev, q}
// ---------------------------------------------------------------------------
module dff_trace_checker #(
    parameter int CYC_W        = 16,
    parameter int CHECK_CYCLES = 10,
    parameter int DEPTH        = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_en,
    input  logic             i_d,
    input  logic             i_q,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [CYC_W-1:0] o_cycle_cnt,
    output logic [CYC_W-1:0] o_err_cnt,
    output logic             o_overflow,
    output logic             o_rec_valid,
    input  logic             i_rec_ready,
    output logic [CYC_W+2:0] o_rec_data
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int RW = CYC_W + 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CYC_W-1:0] LAST_CYC   = CYC_W'(CHECK_CYCLES - 1);
    localparam logic [CYC_W-1:0] CNT_ZERO   = {CYC_W{1'b0}};
    localparam logic [CYC_W-1:0] CNT_MAX    = {CYC_W{1'b1}};
    localparam logic [CYC_W-1:0] CNT_ONE    = CYC_W'(1'b1);
    localparam logic [AW-1:0]    PTR_ZERO   = {AW{1'b0}};
    localparam logic [AW-1:0]    PTR_ONE    = AW'(1'b1);
    localparam logic [AW:0]      OCC_ZERO   = {(AW + 1){1'b0}};
    localparam logic [AW:0]      OCC_ONE    = (AW + 1)'(1'b1);
    localparam logic [AW:0]      OCC_FULL   = (AW + 1)'(DEPTH);
    localparam logic [RW-1:0]    REC_ZERO   = {RW{1'b0}};

    // -----------------------------------------------------------------------
    // State and storage
    // -----------------------------------------------------------------------
    logic [1:0]       r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [CYC_W-1:0] r_cycle_cnt;
    logic [CYC_W-1:0] r_err_cnt;
    logic             r_overflow;
    logic             r_en_prev;
    logic             r_d_prev;
    logic             r_q_prev;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_rec_valid;
    logic [RW-1:0]    r_rec_data;
    logic [RW-1:0]    r_mem [DEPTH];

    // -----------------------------------------------------------------------
    // Check datapath
    // -----------------------------------------------------------------------
    logic          w_run;
    logic          w_predict;
    logic          w_mismatch;
    logic [RW-1:0] w_record;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    assign w_run     = (r_state == ST_RUN);
    assign w_predict = r_en_prev ? r_d_prev : r_q_prev;

    // Cycle 0 has no valid previous sample, so it is only recorded.
    assign w_mismatch = w_run && (r_cycle_cnt != CNT_ZERO) && (w_predict != i_q);
    assign w_record   = {r_cycle_cnt, r_en_prev, r_d_prev, i_q};

    // A same-cycle pop frees the slot a full FIFO needs, so the push can
    // proceed; only a push into a full FIFO without a pop is lost.
    assign w_full = (r_count == OCC_FULL);
    assign w_pop  = r_rec_valid && i_rec_ready;
    assign w_push = w_mismatch && (!w_full || w_pop);
    assign w_drop = w_mismatch && w_full && !w_pop;

    // -----------------------------------------------------------------------
    // Next-state values
    // -----------------------------------------------------------------------
    logic [1:0]       w_state_nxt;
    logic [CYC_W-1:0] w_cycle_nxt;
    logic [CYC_W-1:0] w_err_nxt;
    logic             w_ovf_nxt;
    logic             w_en_prev_nxt;
    logic             w_d_prev_nxt;
    logic             w_q_prev_nxt;
    logic [AW-1:0]    w_wr_nxt;
    logic [AW-1:0]    w_rd_nxt;
    logic [AW:0]      w_count_nxt;
    logic [RW-1:0]    w_head_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_pass_nxt;
    logic             w_rec_valid_nxt;

    // Run control, counters, previous-sample registers and FIFO pointers.
    always_comb begin
        w_state_nxt   = r_state;
        w_cycle_nxt   = r_cycle_cnt;
        w_err_nxt     = r_err_cnt;
        w_ovf_nxt     = r_overflow;
        w_en_prev_nxt = r_en_prev;
        w_d_prev_nxt  = r_d_prev;
        w_q_prev_nxt  = r_q_prev;
        w_wr_nxt      = r_wr_ptr;
        w_rd_nxt      = r_rd_ptr;
        w_count_nxt   = r_count;

        // Ordinary FIFO movement; a run start below overrides it.
        if (w_push) begin
            w_wr_nxt = r_wr_ptr + PTR_ONE;
        end else begin
            w_wr_nxt = r_wr_ptr;
        end

        if (w_pop) begin
            w_rd_nxt = r_rd_ptr + PTR_ONE;
        end else begin
            w_rd_nxt = r_rd_ptr;
        end

        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + OCC_ONE;
            2'b01:   w_count_nxt = r_count - OCC_ONE;
            default: w_count_nxt = r_count;
        endcase

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    // A new run discards everything from the previous one,
                    // including records the reader has not drained yet.
                    w_state_nxt   = ST_RUN;
                    w_cycle_nxt   = CNT_ZERO;
                    w_err_nxt     = CNT_ZERO;
                    w_ovf_nxt     = 1'b0;
                    w_en_prev_nxt = 1'b0;
                    w_d_prev_nxt  = 1'b0;
                    w_q_prev_nxt  = 1'b0;
                    w_wr_nxt      = PTR_ZERO;
                    w_rd_nxt      = PTR_ZERO;
                    w_count_nxt   = OCC_ZERO;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RUN: begin
                w_en_prev_nxt = i_en;
                w_d_prev_nxt  = i_d;
                w_q_prev_nxt  = i_q;
                w_cycle_nxt   = r_cycle_cnt + CNT_ONE;

                if (w_mismatch && (r_err_cnt != CNT_MAX)) begin
                    w_err_nxt = r_err_cnt + CNT_ONE;
                end else begin
                    w_err_nxt = r_err_cnt;
                end

                if (w_drop) begin
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_ovf_nxt = r_overflow;
                end

                if (r_cycle_cnt == LAST_CYC) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Head of the FIFO after this edge; bypass the record being written when
    // it lands in the slot that becomes the head.
    always_comb begin
        if (w_push && (w_rd_nxt == r_wr_ptr)) begin
            w_head_nxt = w_record;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    assign w_busy_nxt      = (w_state_nxt == ST_RUN);
    assign w_done_nxt      = (w_state_nxt == ST_DONE);
    assign w_pass_nxt      = w_done_nxt && (w_err_nxt == CNT_ZERO) && !w_ovf_nxt;
    assign w_rec_valid_nxt = (w_count_nxt != OCC_ZERO);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------

    // Control, counters, pointers and registered output flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_cycle_cnt <= CNT_ZERO;
            r_err_cnt   <= CNT_ZERO;
            r_overflow  <= 1'b0;
            r_en_prev   <= 1'b0;
            r_d_prev    <= 1'b0;
            r_q_prev    <= 1'b0;
            r_wr_ptr    <= PTR_ZERO;
            r_rd_ptr    <= PTR_ZERO;
            r_count     <= OCC_ZERO;
            r_rec_valid <= 1'b0;
            r_rec_data  <= REC_ZERO;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_cycle_cnt <= w_cycle_nxt;
            r_err_cnt   <= w_err_nxt;
            r_overflow  <= w_ovf_nxt;
            r_en_prev   <= w_en_prev_nxt;
            r_d_prev    <= w_d_prev_nxt;
            r_q_prev    <= w_q_prev_nxt;
            r_wr_ptr    <= w_wr_nxt;
            r_rd_ptr    <= w_rd_nxt;
            r_count     <= w_count_nxt;
            r_rec_valid <= w_rec_valid_nxt;
            r_rec_data  <= w_head_nxt;
        end
    end

    // Record storage; contents are only meaningful between the pointers, so
    // it needs no reset.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_mem[r_wr_ptr] <= w_record;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_cycle_cnt = r_cycle_cnt;
    assign o_err_cnt   = r_err_cnt;
    assign o_overflow  = r_overflow;
    assign o_rec_valid = r_rec_valid;
    assign o_rec_data  = r_rec_data;

endmodule

// File: tb/tb_dff_trace_checker.sv
// ---------------------------------------------------------------------------
// tb_dff_trace_checker
//
// Directed bench for dff_trace_checker (CYC_W=16, CHECK_CYCLES=10, DEPTH=8).
// Inputs change 1 ns after a rising edge; outputs are read at that point,
// i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_dff_trace_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        en;
    logic        d;
    logic        q;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] cycle_cnt;
    logic [15:0] err_cnt;
    logic        overflow;
    logic        rec_valid;
    logic        rec_ready;
    logic [18:0] rec_data;

    int n_cmp  = 0;
    int n_fail = 0;

    dff_trace_checker #(
        .CYC_W       (16),
        .CHECK_CYCLES(10),
        .DEPTH       (8)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_en       (en),
        .i_d        (d),
        .i_q        (q),
        .o_busy     (busy),
        .o_done     (done),
        .o_pass     (pass),
        .o_cycle_cnt(cycle_cnt),
        .o_err_cnt  (err_cnt),
        .o_overflow (overflow),
        .o_rec_valid(rec_valid),
        .i_rec_ready(rec_ready),
        .o_rec_data (rec_data)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives n cycles of en<=d, d<=~en with q produced by a correct enabled
    // flop; reports whether rec_valid was ever seen high.
    task automatic drive_good(input int n, output bit seen);
        logic e, dd, mq, nq, ne;
        e = 1'b0; dd = 1'b0; mq = 1'b0; seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            en = e; d = dd; q = mq;
            tick;
            if (rec_valid) seen = 1'b1;
            nq = e ? dd : mq;
            ne = dd;
            dd = ~e;
            e  = ne;
            mq = nq;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; en = 1'b0; d = 1'b0; q = 1'b0; rec_ready = 1'b0;
        tick;
        tick;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", done); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %b exp 0", pass); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
        n_cmp++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rec_valid: got %b exp 0", rec_valid); end
        n_cmp++; if (cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cycle: got %0d exp 0", cycle_cnt); end
        n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err: got %0d exp 0", err_cnt); end
        rst = 1'b0;
        tick;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_start: busy got %b exp 0", busy); end
    endtask

    task automatic test_correct_run;
        bit seen;
        start = 1'b1;
        tick;
        start = 1'b0;
        n_cmp++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL good_start_flags: got %b exp 10", {busy, done}); end
        n_cmp++; if (cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL good_start_cycle: got %0d exp 0", cycle_cnt); end
        drive_good(9, seen);
        n_cmp++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL good_s9_flags: got %b exp 10", {busy, done}); end
        drive_good(1, seen);
        n_cmp++; if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL good_s10_flags: got %b exp 01", {busy, done}); end
        n_cmp++; if (cycle_cnt !== 16'd10) begin n_fail++; $display("FAIL good_cycle: got %0d exp 10", cycle_cnt); end
        n_cmp++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL good_err: got %0d exp 0", err_cnt); end
        n_cmp++; if (pass !== 1'b1) begin n_fail++; $display("FAIL good_pass: got %b exp 1", pass); end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL good_rec_valid_seen: got %b exp 0", seen); end
    endtask

    task automatic test_stuck_overflow;
        logic [18:0] exp_rec;
        start = 1'b1;
        tick;
        start = 1'b0;
        rec_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            en = 1'b1; d = 1'b1; q = 1'b0;
            tick;
            if (k == 1) begin
                n_cmp++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL stuck_first_err: got %0d exp 1", err_cnt); end
                n_cmp++; if (rec_valid !== 1'b1) begin n_fail++; $display("FAIL stuck_first_valid: got %b exp 1", rec_valid); end
                n_cmp++; if (rec_data !== {16'd1, 3'b110}) begin n_fail++; $display("FAIL stuck_first_rec: got %h exp %h", rec_data, {16'd1, 3'b110}); end
            end
        end
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL stuck_done: got %b exp 1", done); end
        n_cmp++; if (err_cnt !== 16'd9) begin n_fail++; $display("FAIL stuck_err: got %0d exp 9", err_cnt); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL stuck_overflow: got %b exp 1", overflow); end
        n_cmp++; if (pass !== 1'b0) begin n_fail++; $display("FAIL stuck_pass: got %b exp 0", pass); end
        rec_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            exp_rec = {16'(k), 3'b110};
            n_cmp++; if ({rec_valid, rec_data} !== {1'b1, exp_rec}) begin n_fail++; $display("FAIL drain_rec_%0d: got v=%b %h exp v=1 %h", k, rec_valid, rec_data, exp_rec); end
            tick;
        end
        n_cmp++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b exp 0", rec_valid); end
        tick;
        rec_ready = 1'b0;
        n_cmp++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL ready_on_empty: got %b exp 0", rec_valid); end
        n_cmp++; if ({cycle_cnt, err_cnt} !== {16'd10, 16'd9}) begin n_fail++; $display("FAIL done_hold: got %0d/%0d exp 10/9", cycle_cnt, err_cnt); end
    endtask

    task automatic test_full_push_pop;
        logic [18:0] exp_rec;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            en = 1'b1; d = 1'b1; q = 1'b0;
            rec_ready = (k == 9);
            tick;
            if (k == 8) begin
                n_cmp++; if ({err_cnt, overflow} !== {16'd8, 1'b0}) begin n_fail++; $display("FAIL full_pre: got err=%0d ovf=%b exp 8/0", err_cnt, overflow); end
            end
        end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pushpop_overflow: got %b exp 0", overflow); end
        n_cmp++; if ({done, pass, err_cnt} !== {1'b1, 1'b0, 16'd9}) begin n_fail++; $display("FAIL full_pushpop_end: got d=%b p=%b e=%0d exp 1/0/9", done, pass, err_cnt); end
        rec_ready = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            exp_rec = {16'(k), 3'b110};
            n_cmp++; if ({rec_valid, rec_data} !== {1'b1, exp_rec}) begin n_fail++; $display("FAIL full_drain_%0d: got v=%b %h exp v=1 %h", k, rec_valid, rec_data, exp_rec); end
            tick;
        end
        rec_ready = 1'b0;
        n_cmp++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain_empty: got %b exp 0", rec_valid); end
    endtask

    task automatic test_start_ignored_and_restart;
        bit seen;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            en = 1'b1; d = 1'b1; q = 1'b0;
            start = (k == 3);
            tick;
            start = 1'b0;
            if (k == 3) begin
                n_cmp++; if ({busy, cycle_cnt, err_cnt} !== {1'b1, 16'd4, 16'd3}) begin n_fail++; $display("FAIL start_in_run: got b=%b c=%0d e=%0d exp 1/4/3", busy, cycle_cnt, err_cnt); end
            end
            if (k == 8) begin
                n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL start_in_run_early_done: got %b exp 0", done); end
            end
        end
        n_cmp++; if ({done, overflow, err_cnt} !== {1'b1, 1'b1, 16'd9}) begin n_fail++; $display("FAIL start_in_run_end: got d=%b o=%b e=%0d exp 1/1/9", done, overflow, err_cnt); end
        start = 1'b1;
        tick;
        start = 1'b0;
        n_cmp++; if ({busy, done, pass} !== 3'b100) begin n_fail++; $display("FAIL restart_flags: got %b exp 100", {busy, done, pass}); end
        n_cmp++; if ({cycle_cnt, err_cnt} !== 32'd0) begin n_fail++; $display("FAIL restart_counters: got %0d/%0d exp 0/0", cycle_cnt, err_cnt); end
        n_cmp++; if ({overflow, rec_valid} !== 2'b00) begin n_fail++; $display("FAIL restart_fifo: got ovf=%b v=%b exp 0/0", overflow, rec_valid); end
        drive_good(10, seen);
        n_cmp++; if ({done, pass, err_cnt} !== {1'b1, 1'b1, 16'd0}) begin n_fail++; $display("FAIL restart_good_run: got d=%b p=%b e=%0d exp 1/1/0", done, pass, err_cnt); end
    endtask

    task automatic test_reset_mid_run;
        bit seen;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            en = 1'b1; d = 1'b1; q = 1'b0;
            tick;
        end
        n_cmp++; if ({err_cnt, rec_valid} !== {16'd4, 1'b1}) begin n_fail++; $display("FAIL midrun_pre: got e=%0d v=%b exp 4/1", err_cnt, rec_valid); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++; if ({busy, done, pass, overflow, rec_valid} !== 5'b00000) begin n_fail++; $display("FAIL midrun_flags: got %b exp 00000", {busy, done, pass, overflow, rec_valid}); end
        n_cmp++; if ({cycle_cnt, err_cnt} !== 32'd0) begin n_fail++; $display("FAIL midrun_counters: got %0d/%0d exp 0/0", cycle_cnt, err_cnt); end
        n_cmp++; if (rec_data !== 19'd0) begin n_fail++; $display("FAIL midrun_rec_data: got %h exp 0", rec_data); end
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        n_cmp++; if ({busy, cycle_cnt} !== {1'b1, 16'd0}) begin n_fail++; $display("FAIL post_rst_start: got b=%b c=%0d exp 1/0", busy, cycle_cnt); end
        drive_good(3, seen);
        n_cmp++; if ({cycle_cnt, err_cnt} !== {16'd3, 16'd0}) begin n_fail++; $display("FAIL post_rst_run: got %0d/%0d exp 3/0", cycle_cnt, err_cnt); end
    endtask

    task automatic test_rst_start_same_edge;
        rst = 1'b1;
        start = 1'b1;
        tick;
        rst = 1'b0;
        start = 1'b0;
        n_cmp++; if ({busy, cycle_cnt} !== {1'b0, 16'd0}) begin n_fail++; $display("FAIL rst_wins: got b=%b c=%0d exp 0/0", busy, cycle_cnt); end
        tick;
        n_cmp++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL rst_wins_idle: got %b exp 00", {busy, done}); end
    endtask

    initial begin
        test_reset;
        test_correct_run;
        test_stuck_overflow;
        test_full_push_pop;
        test_start_ignored_and_restart;
        test_reset_mid_run;
        test_rst_start_same_edge;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dff_trace_checker.md
# dff_trace_checker

Self-checking capture block for the enabled-flop exercise. It samples the `en`/`d` stimulus and the `q` response each clock and predicts `q` from the previous cycle's sampled values. It counts cycles and mismatches and buffers mismatch records in a small FIFO for a downstream reader to drain. It sits on the response side of the stimulus/DUT pair, so a run can be judged in hardware instead of by reading a text log.

## Interface
- `CYC_W`, 16: width of cycle counter, error counter and cycle field of records.
- `CHECK_CYCLES`, 10: number of sampled cycles per run (1 to 2^CYC_W-1).
- `DEPTH`, 8: mismatch FIFO depth, power of two, at least 2.
- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse; begins a run from IDLE or DONE.
- `en` in 1: observed DUT enable.
- `d` in 1: observed DUT data input.
- `q` in 1: observed DUT output.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `pass` out 1: high in DONE when `err_cnt`==0 and `overflow`==0.
- `cycle_cnt` out CYC_W: index of the next cycle to be sampled in the current run.
- `err_cnt` out CYC_W: mismatch count, saturates at all-ones.
- `overflow` out 1: sticky; a mismatch record was dropped because the FIFO was full.
- `rec_valid` out 1: FIFO non-empty.
- `rec_ready` in 1: reader accepts the head record.
- `rec_data` out CYC_W+3: head record {cycle[CYC_W-1:0], en_prev, d_prev, q}.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE on the edge that samples cycle index CHECK_CYCLES-1.
  - DONE→RUN on `start`.
  - `start` is ignored in RUN.
- Entering RUN clears `cycle_cnt`, `err_cnt`, `overflow`, the FIFO and the previous-sample registers.
- Each RUN edge:
  - Samples `en`, `d`, `q` into `en_prev`, `d_prev`, `q_prev`.
  - Increments `cycle_cnt`.
- Prediction for cycle k≥1 is `en_prev ? d_prev : q_prev`.
  - Cycle 0 is sampled but never compared.
  - Mismatch = predicted ≠ sampled `q`.
- On a mismatch:
  - `err_cnt` increments, saturating.
  - The record {k, en_prev, d_prev, q} is pushed to the FIFO.
- FIFO behaviour:
  - Show-ahead; `rec_data` is the head record whenever `rec_valid`=1.
  - Pop when `rec_valid && rec_ready`.
  - Pop is allowed in any state, including IDLE and DONE.
- FIFO full:
  - Push with no same-cycle pop: record dropped, `overflow` set.
  - Push with same-cycle pop: both happen and nothing is dropped.
- `rec_ready` while empty: no effect.
- `rec_data` is don't-care while `rec_valid`=0.
- `cycle_cnt` and `err_cnt` hold their final values in DONE until the next `start` or `rst`.
- Reset values (rst=1 at an edge):
  - State is IDLE.
  - `busy`, `done`, `pass`, `overflow` and `rec_valid` are 0.
  - `cycle_cnt` and `err_cnt` are 0.
  - FIFO pointers are 0.
  - Previous-sample registers are 0.
- `rst` mid-run aborts immediately to the reset values; no record survives.
- `rst` and `start` on the same edge: `rst` wins.

## Timing
- All outputs are registered.
- Latency from sampling edge to visible result:
  - A mismatch sampled at edge E is visible at E: `err_cnt` updated and `rec_valid` high, readable after E.
  - The same applies to an already non-empty FIFO: the new record is queued at E.
- `start` sampled at edge S:
  - `busy`=1 after S.
  - The first sample (cycle 0) is taken at S+1.
  - Cycle k is sampled at S+1+k.
- `done` and `pass` become valid after edge S+CHECK_CYCLES.
- `busy` falls at that same edge; there is no cycle with both `busy` and `done` high.
- A pop at edge P:
  - The next record appears on `rec_data` after P.
  - `rec_valid` drops after P if the FIFO became empty.
- Throughput: one push and one pop per cycle.

## Test plan
- Correct DUT, stimulus `en<=d; d<=~en`, CHECK_CYCLES=10 → `done` after S+10, `cycle_cnt`=10, `err_cnt`=0, `pass`=1, `rec_valid` never 1.
- `q` stuck at 0, `en`=1, `d`=1 constant → 9 mismatches (cycles 1..9), `err_cnt`=9, `pass`=0, first record {1,1,1,0}.
- DEPTH=8 with `rec_ready`=0 and 9 mismatches → 8 records held, `overflow`=1, `pass`=0. Then `rec_ready`=1 drains cycles 1..8 in order over 8 cycles, after which `rec_valid`=0.
- FIFO full with `rec_ready`=1 on a mismatch edge → occupancy stays 8, `overflow` stays 0.
- `rst` at cycle 5 of a failing run → every output is 0 on the next cycle, and a `start` two cycles later restarts with `cycle_cnt`=0.
- `start` pulsed during RUN → ignored, run ends at S+10. `start` in DONE → counters and FIFO cleared, new run begins.
